seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit hex seven-segment driver with once-per-frame input snapshot.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV_BITS  = 17,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num,
    input  logic [3:0]  point,
    input  logic [3:0]  le,
    output logic [7:0]  segment,
    output logic [3:0]  anode,
    output logic        frame_done
);

    localparam logic [3:0] ANODE_OFF = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0] SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [SCAN_DIV_BITS-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]               idx_q, idx_d;
    logic [15:0]              shadow_num_q, shadow_num_d;
    logic [3:0]               shadow_point_q, shadow_point_d;
    logic [3:0]               shadow_le_q, shadow_le_d;
    logic [3:0]               anode_q, anode_d;
    logic [7:0]               segment_q, segment_d;
    logic                     frame_done_q, frame_done_d;

    logic       tick;
    logic       frame_start;
    logic [3:0] cur_nibble;
    logic [3:0] lz_blank;
    logic       dark;
    logic [3:0] anode_hi;
    logic [7:0] seg_hi;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    hex_glyph = 7'h3F;
            4'h1:    hex_glyph = 7'h06;
            4'h2:    hex_glyph = 7'h5B;
            4'h3:    hex_glyph = 7'h4F;
            4'h4:    hex_glyph = 7'h66;
            4'h5:    hex_glyph = 7'h6D;
            4'h6:    hex_glyph = 7'h7D;
            4'h7:    hex_glyph = 7'h07;
            4'h8:    hex_glyph = 7'h7F;
            4'h9:    hex_glyph = 7'h6F;
            4'hA:    hex_glyph = 7'h77;
            4'hB:    hex_glyph = 7'h7C;
            4'hC:    hex_glyph = 7'h39;
            4'hD:    hex_glyph = 7'h5E;
            4'hE:    hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic zero3, zero2, zero1;

    always_comb begin
        zero3    = (shadow_num_q[15:12] == 4'h0);
        zero2    = (shadow_num_q[11:8]  == 4'h0);
        zero1    = (shadow_num_q[7:4]   == 4'h0);
        lz_blank = {zero3, zero3 & zero2, zero3 & zero2 & zero1, 1'b0};
    end
`else
    always_comb begin
        lz_blank = 4'b0000;
    end
`endif

    always_comb begin
        tick        = (div_cnt_q == {SCAN_DIV_BITS{1'b1}});
        frame_start = (div_cnt_q == '0) && (idx_q == 2'd0);

        div_cnt_d    = div_cnt_q + SCAN_DIV_BITS'(1);
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        frame_done_d = tick && (idx_q == 2'd3);

        // The shadow copy is the only thing the output path reads, so the shown value cannot tear mid-frame
        shadow_num_d   = frame_start ? num   : shadow_num_q;
        shadow_point_d = frame_start ? point : shadow_point_q;
        shadow_le_d    = frame_start ? le    : shadow_le_q;

        cur_nibble = shadow_num_q[{idx_q, 2'b00} +: 4];
        dark       = shadow_le_q[idx_q] | lz_blank[idx_q];
        anode_hi   = dark ? 4'b0000 : (4'b0001 << idx_q);
        seg_hi     = {shadow_point_q[idx_q] & ~lz_blank[idx_q], hex_glyph(cur_nibble)};

        anode_d   = SEG_ACTIVE_LOW ? ~anode_hi : anode_hi;
        segment_d = SEG_ACTIVE_LOW ? ~seg_hi   : seg_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            idx_q          <= 2'd0;
            shadow_num_q   <= 16'h0000;
            shadow_point_q <= 4'h0;
            shadow_le_q    <= 4'h0;
            anode_q        <= ANODE_OFF;
            segment_q      <= SEG_OFF;
            frame_done_q   <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            idx_q          <= idx_d;
            shadow_num_q   <= shadow_num_d;
            shadow_point_q <= shadow_point_d;
            shadow_le_q    <= shadow_le_d;
            anode_q        <= anode_d;
            segment_q      <= segment_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign segment    = segment_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV_BITS=2 and active-low outputs.
// edge_n counts clock edges since reset release (E0 is the first edge with rst low).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] num;
    logic [3:0]  point;
    logic [3:0]  le;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        frame_done;

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV_BITS (2),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .point     (point),
        .le        (le),
        .segment   (segment),
        .anode     (anode),
        .frame_done(frame_done)
    );

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'h3F;  4'h1: glyph = 8'h06;  4'h2: glyph = 8'h5B;  4'h3: glyph = 8'h4F;
            4'h4: glyph = 8'h66;  4'h5: glyph = 8'h6D;  4'h6: glyph = 8'h7D;  4'h7: glyph = 8'h07;
            4'h8: glyph = 8'h7F;  4'h9: glyph = 8'h6F;  4'hA: glyph = 8'h77;  4'hB: glyph = 8'h7C;
            4'hC: glyph = 8'h39;  4'hD: glyph = 8'h5E;  4'hE: glyph = 8'h79;  default: glyph = 8'h71;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic reset_and_release(input logic [15:0] n, input logic [3:0] p, input logic [3:0] l);
        rst = 1'b1; num = n; point = p; le = l;
        step();
        step();
        rst = 1'b0;
        edge_n = -1;
    endtask

    task automatic test_reset();
        logic [3:0]  exp_a;
        logic [7:0]  exp_s;
        logic [15:0] val;
        rst = 1'b1; num = 16'hABCD; point = 4'h0; le = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (anode !== 4'hF) begin mismatched++; $display("[TB] FAIL reset_anode: got %h expected %h", anode, 4'hF); end
            compared++;
            if (segment !== 8'hFF) begin mismatched++; $display("[TB] FAIL reset_segment: got %h expected %h", segment, 8'hFF); end
            compared++;
            if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        end
        rst = 1'b0;
        edge_n = -1;
        val = 16'hABCD;
        for (int i = 0; i < 16; i++) begin
            step();
            if (edge_n % 4 == 1) begin
                exp_a = ~(4'b0001 << (edge_n / 4));
                exp_s = ~glyph(val[4*(edge_n/4) +: 4]);
                compared++;
                if (anode !== exp_a) begin mismatched++; $display("[TB] FAIL first_scan_anode n=%0d: got %b expected %b", edge_n, anode, exp_a); end
                compared++;
                if (segment !== exp_s) begin mismatched++; $display("[TB] FAIL first_scan_segment n=%0d: got %h expected %h", edge_n, segment, exp_s); end
            end
        end
    endtask

    task automatic test_frame_timing();
        logic [3:0] exp_a;
        logic       exp_fd;
        int         pulses;
        pulses = 0;
        reset_and_release(16'hABCD, 4'h0, 4'h0);
        for (int i = 0; i < 48; i++) begin
            step();
            exp_fd = (edge_n % 16 == 15);
            exp_a  = ~(4'b0001 << ((edge_n / 4) % 4));
            if (frame_done === 1'b1) pulses++;
            compared++;
            if (frame_done !== exp_fd) begin mismatched++; $display("[TB] FAIL frame_done n=%0d: got %b expected %b", edge_n, frame_done, exp_fd); end
            compared++;
            if (anode !== exp_a) begin mismatched++; $display("[TB] FAIL scan_anode n=%0d: got %b expected %b", edge_n, anode, exp_a); end
        end
        compared++;
        if (pulses != 3) begin mismatched++; $display("[TB] FAIL frame_pulse_count: got %0d expected 3", pulses); end
    endtask

    task automatic test_snapshot();
        logic [7:0]  exp_s;
        logic [15:0] val;
        reset_and_release(16'h1234, 4'h0, 4'h0);
        for (int i = 0; i < 32; i++) begin
            step();
            if (edge_n % 4 == 1) begin
                val   = (edge_n < 16) ? 16'h1234 : 16'h5678;
                exp_s = ~glyph(val[4*((edge_n/4)%4) +: 4]);
                compared++;
                if (segment !== exp_s) begin mismatched++; $display("[TB] FAIL snapshot_segment n=%0d: got %h expected %h", edge_n, segment, exp_s); end
            end
            if (edge_n == 5) num = 16'h5678;
        end
    endtask

    task automatic test_point_blank();
        logic [3:0] exp_a;
        logic [7:0] exp_s;
        reset_and_release(16'h0000, 4'b0100, 4'b1000);
        for (int i = 0; i < 14; i++) begin
            step();
            if (edge_n == 1) begin
                compared++;
                if (anode !== 4'b1110) begin mismatched++; $display("[TB] FAIL pb_digit0_anode: got %b expected 1110", anode); end
                compared++;
                if (segment !== 8'hC0) begin mismatched++; $display("[TB] FAIL pb_digit0_segment: got %h expected c0", segment); end
            end
            if (edge_n == 9) begin
`ifdef LEADING_ZERO_BLANK_EN
                exp_a = 4'hF;    exp_s = 8'hC0;
`else
                exp_a = 4'b1011; exp_s = 8'h40;
`endif
                compared++;
                if (anode !== exp_a) begin mismatched++; $display("[TB] FAIL pb_digit2_anode: got %b expected %b", anode, exp_a); end
                compared++;
                if (segment !== exp_s) begin mismatched++; $display("[TB] FAIL pb_digit2_segment: got %h expected %h", segment, exp_s); end
            end
            if (edge_n == 13) begin
                compared++;
                if (anode !== 4'hF) begin mismatched++; $display("[TB] FAIL pb_digit3_blank: got %b expected 1111", anode); end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0]  exp_a;
        logic [7:0]  exp_s;
        logic [15:0] val;
        reset_and_release(16'hABCD, 4'h0, 4'h0);
        for (int i = 0; i < 10; i++) step();
        num = 16'hE0F9;
        rst = 1'b1;
        step();
        compared++;
        if (anode !== 4'hF) begin mismatched++; $display("[TB] FAIL midrst_anode: got %b expected 1111", anode); end
        compared++;
        if (segment !== 8'hFF) begin mismatched++; $display("[TB] FAIL midrst_segment: got %h expected ff", segment); end
        compared++;
        if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        edge_n = -1;
        val = 16'hE0F9;
        for (int i = 0; i < 14; i++) begin
            step();
            if (edge_n % 4 == 1) begin
                exp_a = ~(4'b0001 << (edge_n / 4));
                exp_s = ~glyph(val[4*(edge_n/4) +: 4]);
                compared++;
                if (anode !== exp_a) begin mismatched++; $display("[TB] FAIL restart_anode n=%0d: got %b expected %b", edge_n, anode, exp_a); end
                compared++;
                if (segment !== exp_s) begin mismatched++; $display("[TB] FAIL restart_segment n=%0d: got %h expected %h", edge_n, segment, exp_s); end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] exp_a [4];
        logic [7:0] exp_s [4];
        exp_a[0] = 4'b1110; exp_s[0] = 8'hC0;
        exp_a[1] = 4'b1101; exp_s[1] = 8'hF8;
`ifdef LEADING_ZERO_BLANK_EN
        exp_a[2] = 4'hF;    exp_s[2] = 8'hC0;
        exp_a[3] = 4'hF;    exp_s[3] = 8'hC0;
`else
        exp_a[2] = 4'b1011; exp_s[2] = 8'hC0;
        exp_a[3] = 4'b0111; exp_s[3] = 8'hC0;
`endif
        reset_and_release(16'h0070, 4'h0, 4'h0);
        for (int i = 0; i < 14; i++) begin
            step();
            if (edge_n % 4 == 1) begin
                compared++;
                if (anode !== exp_a[edge_n/4]) begin mismatched++; $display("[TB] FAIL lz_anode n=%0d: got %b expected %b", edge_n, anode, exp_a[edge_n/4]); end
                compared++;
                if (segment !== exp_s[edge_n/4]) begin mismatched++; $display("[TB] FAIL lz_segment n=%0d: got %h expected %h", edge_n, segment, exp_s[edge_n/4]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; num = 16'h0000; point = 4'h0; le = 4'h0;
        test_reset();
        test_frame_timing();
        test_snapshot();
        test_point_blank();
        test_mid_reset();
        test_leading_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
